// File: rtl/types_pkg.sv
// Shared types for the core front end: RISC-V field encodings used by the
// Controller, the fetch FSM state type and the reset value of the
// instruction register.
// Optional build macro: FETCH_MISALIGN_CHECK_EN adds the FAULT fetch state.
package types_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

    typedef enum logic [6:0] {
        F7_BASE   = 7'b0000000,
        F7_MULDIV = 7'b0000001,
        F7_ALT    = 7'b0100000
    } funct7_e;

    // addi x0, x0, 0 -- harmless contents for the IR before the first fetch
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [2:0] {
        FS_BOOT,
        FS_REQ,
        FS_WAIT,
        FS_HOLD,
        FS_DROP,
        FS_FAULT
    } fetch_state_e;
`else
    typedef enum logic [2:0] {
        FS_BOOT,
        FS_REQ,
        FS_WAIT,
        FS_HOLD,
        FS_DROP
    } fetch_state_e;
`endif

endpackage

// File: rtl/instr_fields.sv
// Combinational split of an instruction word into the fields used by the
// Controller (op/funct3/funct7) and the register specifiers used by the
// datapath (rd/rs1/rs2).
module instr_fields
    import types_pkg::*;
(
    input  logic [31:0] instr,
    output opcode_e     op,
    output funct3_e     funct3,
    output funct7_e     funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    assign op     = opcode_e'(instr[6:0]);
    assign rd     = instr[11:7];
    assign funct3 = funct3_e'(instr[14:12]);
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = funct7_e'(instr[31:25]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Holds the PC, issues one request at a time to a
// variable-latency instruction memory, latches the returned word in the IR
// and offers it to decode. Redirects from execute take priority over every
// other event; fetches already in flight on the wrong path are drained in
// DROP and their data discarded.
// Optional build macro: FETCH_MISALIGN_CHECK_EN -- a redirect to a
// non-word-aligned target parks the unit in FAULT (fetch_fault=1) until an
// aligned redirect arrives. Without it, the target's low two bits are
// cleared and fetch_fault is tied low.
module fetch_unit
    import types_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output opcode_e         op,
    output funct3_e         funct3,
    output funct7_e         funct7,
    output logic            fetch_fault
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            req_valid_q, req_valid_d;
    logic            hold_q, hold_d;

    // Redirect target as loaded into the PC, and the state to enter once no
    // response is outstanding (REQ, or FAULT for a misaligned PC).
    logic [XLEN-1:0] redirect_tgt;
    fetch_state_e    redir_resume;
    fetch_state_e    drop_resume;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign redirect_tgt = redirect_pc;
    assign redir_resume = (redirect_pc[1:0] != 2'b00) ? FS_FAULT : FS_REQ;
    assign drop_resume  = (pc_q[1:0] != 2'b00) ? FS_FAULT : FS_REQ;
    assign fetch_fault  = fault_q;
`else
    logic [1:0] redirect_lsb_unused;

    assign redirect_lsb_unused = redirect_pc[1:0];
    assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
    assign redir_resume        = FS_REQ;
    assign drop_resume         = FS_REQ;
    assign fetch_fault         = 1'b0;
`endif

    // Next-state, PC and IR update; a redirect outranks handshakes and responses.
    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block leaves
        // a signal unassigned and infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;

        if (redirect_valid && state_q != FS_BOOT) begin
            pc_d = redirect_tgt;
            case (state_q)
                // An accepted request still owes a response, so it must be drained.
                FS_REQ:  state_d = imem_req_ready ? FS_DROP : redir_resume;
                FS_WAIT: state_d = imem_rsp_valid ? redir_resume : FS_DROP;
                FS_DROP: state_d = imem_rsp_valid ? redir_resume : FS_DROP;
                default: state_d = redir_resume;
            endcase
        end else begin
            case (state_q)
                FS_BOOT: state_d = FS_REQ;
                FS_REQ: begin
                    if (imem_req_ready) state_d = FS_WAIT;
                end
                FS_WAIT: begin
                    if (imem_rsp_valid) begin
                        ir_d    = imem_rsp_data;
                        state_d = FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (if_ready) begin
                        pc_d    = pc_q + XLEN'(4);
                        state_d = FS_REQ;
                    end
                end
                FS_DROP: begin
                    if (imem_rsp_valid) state_d = drop_resume;
                end
                default: state_d = state_q;
            endcase
        end

        req_valid_d = (state_d == FS_REQ);
        hold_d      = (state_d == FS_HOLD);
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d     = (state_d == FS_FAULT);
`endif
    end

    // State, PC, IR and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FS_BOOT;
            pc_q        <= RESET_PC;
            ir_q        <= NOP_INSTR;
            req_valid_q <= 1'b0;
            hold_q      <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            req_valid_q <= req_valid_d;
            hold_q      <= hold_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;

    // A redirect in HOLD masks if_valid so decode cannot consume a wrong-path word.
    assign if_valid    = hold_q && !redirect_valid;
    assign if_instr    = ir_q;
    assign if_pc       = pc_q;
    assign if_pc_plus4 = pc_q + XLEN'(4);

    logic [4:0] rd_unused;
    logic [4:0] rs1_unused;
    logic [4:0] rs2_unused;

    instr_fields u_instr_fields (
        .instr  (ir_q),
        .op     (op),
        .funct3 (funct3),
        .funct7 (funct7),
        .rd     (rd_unused),
        .rs1    (rs1_unused),
        .rs2    (rs2_unused)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset state, the 3-cycle fetch sequence,
// decode back-pressure, redirects in every state, PC wrap and async reset.
// With FETCH_MISALIGN_CHECK_EN defined it also exercises the FAULT state.
module tb_fetch_unit;
    import types_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    opcode_e     op;
    funct3_e     funct3;
    funct7_e     funct7;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .op             (op),
        .funct3         (funct3),
        .funct7         (funct7),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs before sampling.
    task automatic settle();
        #1;
    endtask

    // Starting in REQ: check the address, accept it, return word one cycle
    // later and check the word presented in HOLD.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
        settle();
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
        check({tag, "_req_addr"}, imem_req_addr, addr);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        settle();
        check({tag, "_wait_if_valid"}, 32'(if_valid), 32'd0);
        check({tag, "_wait_req_valid"}, 32'(imem_req_valid), 32'd0);
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        settle();
        check({tag, "_if_valid"}, 32'(if_valid), 32'd1);
        check({tag, "_if_instr"}, if_instr, word);
        check({tag, "_if_pc"}, if_pc, addr);
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
    endtask

    task automatic redirect_clear();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_ir_nop", if_instr, 32'h0000_0013);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_pc_plus4", if_pc_plus4, 32'h4);

        // BOOT cycle issues no request; REQ follows
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        check("boot_req_valid", 32'(imem_req_valid), 32'd0);
        step();

        // addi x1, x0, 5 at 0x0, consumed the cycle it appears
        fetch("f0", 32'h0, 32'h0050_0093);
        check("f0_op", 32'(op), 32'h13);
        check("f0_funct3", 32'(funct3), 32'h0);
        check("f0_pc_plus4", if_pc_plus4, 32'h4);
        if_ready = 1'b1;
        settle();
        check("f0_consume_valid", 32'(if_valid), 32'd1);
        step();
        if_ready = 1'b0;

        // sw x10, 0(x2) at 0x4 held by decode for 5 cycles
        fetch("f1", 32'h4, 32'h00A1_2023);
        check("f1_op", 32'(op), 32'h23);
        check("f1_funct3", 32'(funct3), 32'h2);
        for (int i = 0; i < 5; i++) begin
            step();
            settle();
            check("stall_if_valid", 32'(if_valid), 32'd1);
            check("stall_if_instr", if_instr, 32'h00A1_2023);
            check("stall_if_pc", if_pc, 32'h4);
            check("stall_no_req", 32'(imem_req_valid), 32'd0);
        end
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        settle();
        check("f1_next_addr", imem_req_addr, 32'h8);

        // Redirect to 0x100 while in WAIT; stale response arrives 3 cycles later
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_to(32'h100);
        settle();
        check("wait_redir_if_valid", 32'(if_valid), 32'd0);
        step();
        redirect_clear();
        settle();
        check("drop1_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        settle();
        check("drop2_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        settle();
        check("drop3_if_valid", 32'(if_valid), 32'd0);
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        settle();
        check("drop_ir_kept", if_instr, 32'h00A1_2023);
        check("drop_if_valid", 32'(if_valid), 32'd0);

        // add x3, x1, x2 at 0x100
        fetch("f2", 32'h100, 32'h0020_81B3);
        check("f2_op", 32'(op), 32'h33);
        check("f2_funct7", 32'(funct7), 32'h00);

        // Redirect to 0x200 in HOLD with decode ready: no handshake
        if_ready = 1'b1;
        redirect_to(32'h200);
        settle();
        check("hold_redir_if_valid", 32'(if_valid), 32'd0);
        step();
        if_ready = 1'b0;
        redirect_clear();
        settle();
        check("hold_redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("hold_redir_addr", imem_req_addr, 32'h200);
        check("hold_redir_ir_kept", if_instr, 32'h0020_81B3);

        // Redirect in REQ while imem is not ready: request retargeted
        redirect_to(32'hFFFF_FFFC);
        step();
        redirect_clear();

        // sub x10, x10, x11 at the top of the address space; PC wraps
        fetch("f3", 32'hFFFF_FFFC, 32'h40B5_0533);
        check("f3_funct7", 32'(funct7), 32'h20);
        check("f3_pc_plus4", if_pc_plus4, 32'h0);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        settle();
        check("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        check("wrap_addr", imem_req_addr, 32'h0);

        // Redirect in the same cycle the request is accepted: drain then 0x300
        imem_req_ready = 1'b1;
        redirect_to(32'h300);
        step();
        imem_req_ready = 1'b0;
        redirect_clear();
        settle();
        check("acc_redir_req_valid", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        settle();
        check("acc_redir_addr", imem_req_addr, 32'h300);
        check("acc_redir_req_valid2", 32'(imem_req_valid), 32'd1);
        check("acc_redir_ir_kept", if_instr, 32'h40B5_0533);

        // Redirect in WAIT coinciding with the response: data discarded, 0x400
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h2222_2222;
        redirect_to(32'h400);
        settle();
        check("rsp_redir_if_valid", 32'(if_valid), 32'd0);
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_clear();
        settle();
        check("rsp_redir_addr", imem_req_addr, 32'h400);
        check("rsp_redir_ir_kept", if_instr, 32'h40B5_0533);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect with nothing outstanding: straight to FAULT
        redirect_to(32'h102);
        step();
        redirect_clear();
        settle();
        check("fault_flag", 32'(fetch_fault), 32'd1);
        check("fault_no_req", 32'(imem_req_valid), 32'd0);
        check("fault_if_valid", 32'(if_valid), 32'd0);
        step();
        settle();
        check("fault_flag_held", 32'(fetch_fault), 32'd1);
        check("fault_no_req_held", 32'(imem_req_valid), 32'd0);
        redirect_to(32'h104);
        step();
        redirect_clear();
        settle();
        check("fault_clear", 32'(fetch_fault), 32'd0);
        check("fault_clear_req", 32'(imem_req_valid), 32'd1);
        check("fault_clear_addr", imem_req_addr, 32'h104);

        // Misaligned redirect as the request is accepted: DROP then FAULT
        imem_req_ready = 1'b1;
        redirect_to(32'h106);
        step();
        imem_req_ready = 1'b0;
        redirect_clear();
        settle();
        check("dropfault_in_drop", 32'(fetch_fault), 32'd0);
        check("dropfault_no_req", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h3333_3333;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        settle();
        check("dropfault_flag", 32'(fetch_fault), 32'd1);
        check("dropfault_no_req2", 32'(imem_req_valid), 32'd0);
        redirect_to(32'h500);
        step();
        redirect_clear();
        settle();
        check("dropfault_clear_addr", imem_req_addr, 32'h500);
        check("dropfault_clear", 32'(fetch_fault), 32'd0);
`else
        // Misaligned target has its low bits cleared; no fault exists
        redirect_to(32'h502);
        step();
        redirect_clear();
        settle();
        check("align_addr", imem_req_addr, 32'h500);
        check("align_req_valid", 32'(imem_req_valid), 32'd1);
        check("align_no_fault", 32'(fetch_fault), 32'd0);
`endif

        // Async reset while a request is outstanding, redirect ignored in BOOT
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        settle();
        check("arst_req_valid", 32'(imem_req_valid), 32'd0);
        check("arst_if_valid", 32'(if_valid), 32'd0);
        check("arst_ir_nop", if_instr, 32'h0000_0013);
        check("arst_if_pc", if_pc, 32'h0);
        redirect_to(32'h700);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        redirect_clear();
        settle();
        check("boot_redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("boot_redir_ignored", imem_req_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the Controller and datapath.
- Holds the PC and issues one-at-a-time requests to a variable-latency instruction memory over a valid/ready handshake.
- Captures the returned word in an instruction register and presents it to decode, with op/funct3/funct7 split out for the Controller.
- Applies control-flow redirects from execute, discarding wrong-path fetches.

Parameters:
- XLEN, 32, width of PC and addresses
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  imem accepts request
- imem_req_addr  output  XLEN  fetch address (= PC)
- imem_rsp_valid  input  1  response data valid, single-cycle pulse
- imem_rsp_data  input  32  instruction word
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_pc  input  XLEN  redirect target
- if_valid  output  1  instruction available to decode
- if_ready  input  1  decode consumes instruction
- if_instr  output  32  instruction register
- if_pc  output  XLEN  PC of if_instr
- if_pc_plus4  output  XLEN  if_pc + 4, modulo 2^XLEN
- op  output  opcode_e  if_instr[6:0]
- funct3  output  funct3_e  if_instr[14:12]
- funct7  output  funct7_e  if_instr[31:25]
- fetch_fault  output  1  misaligned redirect fault (see Optional Feature)

Behaviour:
- Reset (async assert, sync release):
  - state=BOOT, pc=RESET_PC, IR=32'h0000_0013 (NOP).
  - imem_req_valid=0, if_valid=0, fetch_fault=0.
- States: BOOT, REQ, WAIT, HOLD, DROP, FAULT.
- BOOT: unconditionally -> REQ on the next cycle.
- REQ:
  - imem_req_valid=1, addr=pc.
  - On req_ready -> WAIT.
- WAIT: on rsp_valid -> IR<=rsp_data, -> HOLD.
- HOLD:
  - if_valid=1 and if_pc=pc.
  - On if_valid&&if_ready: pc<=pc+4 (wraps), -> REQ.
- At most one request outstanding; responses arrive in order.
- Minimum 3 cycles per instruction:
  - req accepted in cycle N;
  - rsp in cycle N+1;
  - if_valid from N+2;
  - consumed in N+2;
  - next req in N+3.
- Redirect has priority over every other event. pc<=redirect_pc in any state except BOOT. Effect per state:
  - REQ, req_ready=0: stay in REQ; the address changes to the target next cycle (request abort is permitted only on redirect).
  - REQ, req_ready=1: the old request is already in flight -> DROP.
  - WAIT, no rsp: -> DROP.
  - WAIT, rsp same cycle: discard the data, -> REQ.
  - HOLD: if_valid is forced to 0 combinationally while redirect_valid=1, so no handshake occurs. IR is not consumed; -> REQ.
  - DROP: the pending response is awaited and discarded.
- DROP:
  - imem_req_valid=0.
  - On rsp_valid -> REQ; rsp data is never written to IR.
  - A redirect in DROP updates pc only.
- Redirect during BOOT is ignored.
- Async reset mid-transaction returns to BOOT immediately. imem must itself be reset by the same rst_n, so no stale response exists after reset.
- IR, if_pc and the field outputs stay stable while if_valid=1 and if_ready=0.

Optional Feature:
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 loads pc and enters FAULT, or DROP-then-FAULT if a response is outstanding.
  - FAULT: fetch_fault=1, if_valid=0, no requests.
  - An aligned redirect clears the fault -> REQ.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00.
  - FAULT state is absent and fetch_fault is tied to 0.

Decomposition:
- types_pkg gains fetch_state_e and the NOP_INSTR constant (32'h0000_0013).
- opcode_e, funct3_e and funct7_e are reused from types_pkg unchanged.
- One sub-module, instr_fields: a combinational split of if_instr into op/funct3/funct7 (plus rd/rs1/rs2 for datapath reuse).

Test Plan:
- Reset release, req_ready=1, 1-cycle rsp of 32'h00500093 -> req addr 0x0, if_valid in cycle 3, op=OP_IMM, funct3=0. After consume, next addr=0x4.
- if_ready=0 for 5 cycles in HOLD -> if_instr/if_pc stable, no new request. Then consume -> addr=pc+4.
- Redirect to 0x100 while WAIT; rsp arrives 3 cycles later -> that data is never shown. Next request addr=0x100.
- Redirect to 0x200 in HOLD with if_ready=1 same cycle -> if_valid=0 that cycle, no consume. Next request 0x200.
- pc=0xFFFF_FFFC consumed -> next addr=0x0000_0000 (wrap).
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> fetch_fault=1, no requests. Redirect to 0x104 -> fault clears, request 0x104.
